// File: rtl/cordic_axi4s_arbiter.sv
// Round-robin sharing of one CORDIC AXI4-S pipeline between several requesters.
// Includes credit-based issue throttling and result routing by the requester index carried in tid.
`timescale 1ns/1ps
module cordic_axi4s_arbiter #(
  parameter int NR_OF_REQUESTERS_P = 4,
  parameter int AXI_DATA_WIDTH_P   = 16,
  parameter int AXI_ID_WIDTH_P     = 4,
  parameter int MAX_OUTSTANDING_P  = 16,
  localparam int SEL_WIDTH_C = $clog2(NR_OF_REQUESTERS_P),
  localparam int CNT_WIDTH_C = $clog2(MAX_OUTSTANDING_P + 1),
  localparam int TID_WIDTH_C = AXI_ID_WIDTH_P + SEL_WIDTH_C
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NR_OF_REQUESTERS_P-1:0]                      ing_tvalid,
  output logic [NR_OF_REQUESTERS_P-1:0]                      ing_tready,
  input  logic [NR_OF_REQUESTERS_P-1:0][AXI_DATA_WIDTH_P-1:0] ing_tdata,
  input  logic [NR_OF_REQUESTERS_P-1:0][AXI_ID_WIDTH_P-1:0]   ing_tid,
  input  logic [NR_OF_REQUESTERS_P-1:0]                      ing_tuser,
  output logic                                               cor_tvalid,
  output logic [AXI_DATA_WIDTH_P-1:0]                        cor_tdata,
  output logic [TID_WIDTH_C-1:0]                             cor_tid,
  output logic                                               cor_tuser,
  input  logic                                               cor_egr_tvalid,
  input  logic [AXI_DATA_WIDTH_P-1:0]                        cor_egr_tdata,
  input  logic [TID_WIDTH_C-1:0]                             cor_egr_tid,
  output logic [NR_OF_REQUESTERS_P-1:0]                      egr_tvalid,
  output logic [AXI_DATA_WIDTH_P-1:0]                        egr_tdata,
  output logic [AXI_ID_WIDTH_P-1:0]                          egr_tid,
  output logic [CNT_WIDTH_C-1:0]                             outstanding,
  output logic                                               busy,
  output logic                                               route_err
);

  localparam logic [SEL_WIDTH_C:0]          NR_C      = (SEL_WIDTH_C+1)'(NR_OF_REQUESTERS_P);
  localparam logic [SEL_WIDTH_C:0]          SEL_ONE_C = (SEL_WIDTH_C+1)'(1);
  localparam logic [CNT_WIDTH_C:0]          MAX_C     = (CNT_WIDTH_C+1)'(MAX_OUTSTANDING_P);
  localparam logic [CNT_WIDTH_C-1:0]        CNT_ONE_C = CNT_WIDTH_C'(1);
  localparam logic [NR_OF_REQUESTERS_P-1:0] ONE_C     = NR_OF_REQUESTERS_P'(1);

  logic [SEL_WIDTH_C-1:0]        rr_ptr_q, rr_ptr_d;
  logic                          cor_tvalid_q, cor_tvalid_d;
  logic [AXI_DATA_WIDTH_P-1:0]   cor_tdata_q, cor_tdata_d;
  logic [TID_WIDTH_C-1:0]        cor_tid_q, cor_tid_d;
  logic                          cor_tuser_q, cor_tuser_d;
  logic [NR_OF_REQUESTERS_P-1:0] egr_tvalid_q, egr_tvalid_d;
  logic [AXI_DATA_WIDTH_P-1:0]   egr_tdata_q, egr_tdata_d;
  logic [AXI_ID_WIDTH_P-1:0]     egr_tid_q, egr_tid_d;
  logic [CNT_WIDTH_C-1:0]        outstanding_q, outstanding_d;
  logic                          route_err_q, route_err_d;

  logic                          credit_ok_s, gnt_found_s, xfer_s, sel_ok_s, underflow_s;
  logic [SEL_WIDTH_C-1:0]        gnt_idx_s, egr_sel_s;
  logic [SEL_WIDTH_C:0]          idx_s, nxt_s;

  assign credit_ok_s = ({1'b0, outstanding_q} + {{CNT_WIDTH_C{1'b0}}, cor_tvalid_q}) < MAX_C;

  // First valid requester at or after rr_ptr_q, wrapping modulo the requester count.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    idx_s       = '0;
    for (int k = 0; k < NR_OF_REQUESTERS_P; k++) begin
      idx_s = {1'b0, rr_ptr_q} + k[SEL_WIDTH_C:0];
      idx_s = (idx_s >= NR_C) ? (idx_s - NR_C) : idx_s;
      if (!gnt_found_s && ing_tvalid[idx_s[SEL_WIDTH_C-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = idx_s[SEL_WIDTH_C-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign xfer_s     = gnt_found_s & credit_ok_s;
  assign ing_tready = (xfer_s & ~rst) ? (ONE_C << gnt_idx_s) : '0;
  assign nxt_s      = {1'b0, gnt_idx_s} + SEL_ONE_C;

  // Issue stage: capture the granted request and advance the pointer past it.
  always_comb begin
    cor_tvalid_d = xfer_s;
    cor_tdata_d  = '0;
    cor_tid_d    = '0;
    cor_tuser_d  = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    if (xfer_s) begin
      cor_tdata_d = ing_tdata[gnt_idx_s];
      cor_tid_d   = {gnt_idx_s, ing_tid[gnt_idx_s]};
      cor_tuser_d = ing_tuser[gnt_idx_s];
      rr_ptr_d    = (nxt_s >= NR_C) ? '0 : nxt_s[SEL_WIDTH_C-1:0];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  assign egr_sel_s = cor_egr_tid[TID_WIDTH_C-1:AXI_ID_WIDTH_P];

  // Only a non-power-of-two requester count can yield an out-of-range index.
  generate
    if ((1 << SEL_WIDTH_C) == NR_OF_REQUESTERS_P) begin : g_sel_full
      assign sel_ok_s = 1'b1;
    end else begin : g_sel_part
      assign sel_ok_s = ({1'b0, egr_sel_s} < NR_C);
    end
  endgenerate

  // Egress stage: route the returning result to its owner by index.
  always_comb begin
    egr_tvalid_d = '0;
    egr_tdata_d  = '0;
    egr_tid_d    = '0;
    if (cor_egr_tvalid) begin
      egr_tvalid_d = sel_ok_s ? (ONE_C << egr_sel_s) : '0;
      egr_tdata_d  = cor_egr_tdata;
      egr_tid_d    = cor_egr_tid[AXI_ID_WIDTH_P-1:0];
    end else begin
      egr_tvalid_d = '0;
    end
  end

  assign underflow_s = cor_egr_tvalid & ~cor_tvalid_q & (outstanding_q == '0);
  assign route_err_d = route_err_q | underflow_s | (cor_egr_tvalid & ~sel_ok_s);

  // In-flight accounting: issue counts up, return counts down, clamped at both ends.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({cor_tvalid_q, cor_egr_tvalid})
      2'b10: outstanding_d = ({1'b0, outstanding_q} < MAX_C) ? (outstanding_q + CNT_ONE_C) : outstanding_q;
      2'b01: outstanding_d = (outstanding_q != '0) ? (outstanding_q - CNT_ONE_C) : outstanding_q;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      cor_tvalid_q  <= 1'b0;
      cor_tdata_q   <= '0;
      cor_tid_q     <= '0;
      cor_tuser_q   <= 1'b0;
      egr_tvalid_q  <= '0;
      egr_tdata_q   <= '0;
      egr_tid_q     <= '0;
      outstanding_q <= '0;
      route_err_q   <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cor_tvalid_q  <= cor_tvalid_d;
      cor_tdata_q   <= cor_tdata_d;
      cor_tid_q     <= cor_tid_d;
      cor_tuser_q   <= cor_tuser_d;
      egr_tvalid_q  <= egr_tvalid_d;
      egr_tdata_q   <= egr_tdata_d;
      egr_tid_q     <= egr_tid_d;
      outstanding_q <= outstanding_d;
      route_err_q   <= route_err_d;
    end
  end

  assign cor_tvalid  = cor_tvalid_q;
  assign cor_tdata   = cor_tdata_q;
  assign cor_tid     = cor_tid_q;
  assign cor_tuser   = cor_tuser_q;
  assign egr_tvalid  = egr_tvalid_q;
  assign egr_tdata   = egr_tdata_q;
  assign egr_tid     = egr_tid_q;
  assign outstanding = outstanding_q;
  assign route_err   = route_err_q;
  assign busy        = (outstanding_q != '0) | cor_tvalid_q;

endmodule

// File: tb/tb_cordic_axi4s_arbiter.sv
// Scoreboard bench for cordic_axi4s_arbiter with three requesters and a limit of six in flight.
// Stimulus is random or directed; expected responses come from an integer reference model.
`timescale 1ns/1ps
module tb_cordic_axi4s_arbiter;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int IDW = 4;
  localparam int MAX = 6;
  localparam int SEL = 2;
  localparam int TW  = IDW + SEL;
  localparam int CW  = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          ing_tvalid = '0;
  logic [N-1:0]          ing_tready;
  logic [N-1:0][DW-1:0]  ing_tdata = '0;
  logic [N-1:0][IDW-1:0] ing_tid = '0;
  logic [N-1:0]          ing_tuser = '0;
  logic                  cor_tvalid;
  logic [DW-1:0]         cor_tdata;
  logic [TW-1:0]         cor_tid;
  logic                  cor_tuser;
  logic                  cor_egr_tvalid = 1'b0;
  logic [DW-1:0]         cor_egr_tdata = '0;
  logic [TW-1:0]         cor_egr_tid = '0;
  logic [N-1:0]          egr_tvalid;
  logic [DW-1:0]         egr_tdata;
  logic [IDW-1:0]        egr_tid;
  logic [CW-1:0]         outstanding;
  logic                  busy;
  logic                  route_err;

  cordic_axi4s_arbiter #(
    .NR_OF_REQUESTERS_P(N), .AXI_DATA_WIDTH_P(DW), .AXI_ID_WIDTH_P(IDW), .MAX_OUTSTANDING_P(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .ing_tvalid(ing_tvalid), .ing_tready(ing_tready), .ing_tdata(ing_tdata),
    .ing_tid(ing_tid), .ing_tuser(ing_tuser),
    .cor_tvalid(cor_tvalid), .cor_tdata(cor_tdata), .cor_tid(cor_tid), .cor_tuser(cor_tuser),
    .cor_egr_tvalid(cor_egr_tvalid), .cor_egr_tdata(cor_egr_tdata), .cor_egr_tid(cor_egr_tid),
    .egr_tvalid(egr_tvalid), .egr_tdata(egr_tdata), .egr_tid(egr_tid),
    .outstanding(outstanding), .busy(busy), .route_err(route_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic [TW-1:0] id; logic u; } cor_t;
  typedef struct packed { logic [N-1:0] v; logic [DW-1:0] d; logic [IDW-1:0] id; } egr_t;

  cor_t          cor_q[$];
  egr_t          egr_q[$];
  logic [TW-1:0] flight[$];

  int rr_m, out_m;
  bit ctv_m, err_m;

  bit             pv[N];
  logic [DW-1:0]  pd[N];
  logic [IDW-1:0] pt[N];
  logic           pu[N];

  int            req_prob, ret_prob;
  bit            ret_force;
  logic [TW-1:0] f_tid;
  logic [DW-1:0] f_dat;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero();
    chk("rst_ing_tready", ing_tready, 0);
    chk("rst_cor_tvalid", cor_tvalid, 0);
    chk("rst_cor_payload", {cor_tdata, cor_tid, cor_tuser}, 0);
    chk("rst_egr_tvalid", egr_tvalid, 0);
    chk("rst_egr_payload", {egr_tdata, egr_tid}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_route_err", route_err, 0);
  endtask

  // Asserts reset at the current time, checks the asynchronous clear, then releases at a negedge.
  task automatic rst_now();
    rst = 1'b1;
    #1;
    chk_zero();
    rr_m = 0; out_m = 0; ctv_m = 1'b0; err_m = 1'b0;
    cor_q.delete(); egr_q.delete(); flight.delete();
    ing_tvalid = '0;
    cor_egr_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_now();
  endtask

  // One clock of stimulus plus reference-model prediction for it.
  task automatic run_cycle();
    bit            e, credit, xf;
    int            g, sel;
    logic [TW-1:0] rtid;
    logic [DW-1:0] rdat;
    logic [N-1:0]  exp_rdy;
    cor_t          ce;
    egr_t          ee;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && ($urandom_range(99) < req_prob)) begin
        pv[i] = 1'b1;
        pd[i] = DW'($urandom);
        pt[i] = IDW'($urandom);
        pu[i] = 1'($urandom);
      end
    end
    e = 1'b0;
    rtid = '0;
    rdat = DW'($urandom);
    if (ret_force) begin
      e = 1'b1; rtid = f_tid; rdat = f_dat;
    end else if (flight.size() > 0 && ($urandom_range(99) < ret_prob)) begin
      e = 1'b1; rtid = flight.pop_front();
    end
    for (int i = 0; i < N; i++) begin
      ing_tvalid[i] = pv[i];
      ing_tdata[i]  = pd[i];
      ing_tid[i]    = pt[i];
      ing_tuser[i]  = pu[i];
    end
    cor_egr_tvalid = e;
    cor_egr_tid    = rtid;
    cor_egr_tdata  = rdat;
    #1;
    credit = (out_m + int'(ctv_m)) < MAX;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && pv[(rr_m + k) % N]) g = (rr_m + k) % N;
    end
    xf = credit && (g >= 0);
    exp_rdy = '0;
    if (xf) exp_rdy[g] = 1'b1;
    chk("ing_tready", ing_tready, exp_rdy);
    chk("outstanding", outstanding, out_m);
    chk("busy", busy, (out_m != 0) || ctv_m);
    chk("route_err", route_err, err_m);
    if (xf) begin
      ce.d  = pd[g];
      ce.id = TW'(g * (1 << IDW) + int'(pt[g]));
      ce.u  = pu[g];
      cor_q.push_back(ce);
      flight.push_back(ce.id);
      pv[g] = 1'b0;
    end
    if (e) begin
      sel = int'(rtid) >> IDW;
      if (sel >= N) begin
        err_m = 1'b1;
      end else begin
        ee.v = '0;
        ee.v[sel] = 1'b1;
        ee.d = rdat;
        ee.id = rtid[IDW-1:0];
        egr_q.push_back(ee);
      end
    end
    if (ctv_m && !e) out_m = (out_m < MAX) ? out_m + 1 : out_m;
    else if (e && !ctv_m) begin
      if (out_m > 0) out_m--;
      else err_m = 1'b1;
    end
    ctv_m = xf;
    if (xf) rr_m = (g + 1) % N;
  endtask

  task automatic drain();
    req_prob = 0; ret_prob = 100;
    for (int c = 0; c < 60 && (flight.size() > 0 || ctv_m || out_m > 0); c++) run_cycle();
    ret_prob = 0;
    run_cycle();
    chk("drained_outstanding", outstanding, 0);
  endtask

  // Monitor: compares every presented output against the scoreboard queues.
  initial begin
    cor_t ce;
    egr_t ee;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (cor_tvalid || cor_q.size() > 0) begin
          if (cor_q.size() == 0) begin
            chk("cor_unexpected", cor_tvalid, 0);
          end else begin
            ce = cor_q.pop_front();
            chk("cor_tvalid", cor_tvalid, 1);
            chk("cor_tdata", cor_tdata, ce.d);
            chk("cor_tid", cor_tid, ce.id);
            chk("cor_tuser", cor_tuser, ce.u);
          end
        end else begin
          chk("cor_idle", {cor_tdata, cor_tid, cor_tuser}, 0);
        end
        if (egr_tvalid != '0 || egr_q.size() > 0) begin
          if (egr_q.size() == 0) begin
            chk("egr_unexpected", egr_tvalid, 0);
          end else begin
            ee = egr_q.pop_front();
            chk("egr_tvalid", egr_tvalid, ee.v);
            chk("egr_tdata", egr_tdata, ee.d);
            chk("egr_tid", egr_tid, ee.id);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pd[i] = '0; pt[i] = '0; pu[i] = 1'b0;
    end
    req_prob = 0; ret_prob = 0; ret_force = 1'b0; f_tid = '0; f_dat = '0;
    rr_m = 0; out_m = 0; ctv_m = 1'b0; err_m = 1'b0;
    @(negedge clk);
    rst_now();

    // Single request from port 2 and its return.
    pv[2] = 1'b1; pd[2] = 16'h1000; pt[2] = 4'd3; pu[2] = 1'b1;
    run_cycle();
    run_cycle();
    chk("single_cor_tid", cor_tid, 6'h23);
    ret_force = 1'b1; f_tid = 6'h23; f_dat = 16'h5A5A;
    run_cycle();
    ret_force = 1'b0;
    flight.delete();
    run_cycle();
    chk("single_egr_tvalid", egr_tvalid, 3'b100);
    chk("single_egr_tid", egr_tid, 4'd3);
    chk("single_egr_tdata", egr_tdata, 16'h5A5A);

    // All ports busy, nothing returns: credit limit stops issue.
    req_prob = 100; ret_prob = 0;
    repeat (10) run_cycle();
    chk("throttle_outstanding", outstanding, 6);
    chk("throttle_tready", ing_tready, 0);
    ret_prob = 100;
    run_cycle();
    ret_prob = 0;
    repeat (4) run_cycle();
    chk("one_more_outstanding", outstanding, 6);
    chk("one_more_tready", ing_tready, 0);
    drain();

    // Random traffic.
    req_prob = 40; ret_prob = 50;
    repeat (400) run_cycle();
    drain();

    // Return with nothing in flight.
    ret_force = 1'b1; f_tid = 6'h05; f_dat = 16'hBEEF;
    run_cycle();
    ret_force = 1'b0;
    run_cycle();
    chk("underflow_err", route_err, 1);
    chk("underflow_out", outstanding, 0);

    // Out-of-range requester index on return.
    do_reset();
    req_prob = 0;
    pv[0] = 1'b1; pd[0] = 16'h0123; pt[0] = 4'd9; pu[0] = 1'b0;
    run_cycle();
    run_cycle();
    ret_force = 1'b1; f_tid = 6'h31; f_dat = 16'h7777;
    run_cycle();
    ret_force = 1'b0;
    flight.delete();
    run_cycle();
    chk("bad_sel_err", route_err, 1);
    chk("bad_sel_out", outstanding, 0);
    chk("bad_sel_egr_tvalid", egr_tvalid, 0);

    // Reset while five are in flight and a request is being presented.
    do_reset();
    req_prob = 100; ret_prob = 0;
    for (int c = 0; c < 20 && !(out_m == 5 && ctv_m); c++) run_cycle();
    @(negedge clk);
    chk("pre_rst_outstanding", outstanding, 5);
    chk("pre_rst_cor_tvalid", cor_tvalid, 1);
    rst_now();
    run_cycle();
    chk("post_rst_grant", ing_tready, 3'b001);
    drain();

    // Heavier random traffic.
    req_prob = 70; ret_prob = 60;
    repeat (200) run_cycle();
    drain();
    repeat (2) @(negedge clk);
    chk("cor_queue_empty", cor_q.size(), 0);
    chk("egr_queue_empty", egr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
